wb_ctl_pipe: RTL and testbench

Parametrised writeback-control pipeline for the rv32 core. Decodes each accepted instruction into writeback select, register-write enable and destination register. Carries that control through a configurable number of pipeline stages to the writeback port. Adds valid tracking, global stall, partial flush, x0 write suppression, load-use interlock and per-stage RAW match vectors for the forwarding/hazard unit.

---
 rtl/wb_ctl_pkg.sv | 47 ++++
 rtl/wb_ctl_dec.sv | 41 ++++
 rtl/wb_ctl_pipe.sv | 109 ++++++++++
 tb/tb_wb_ctl_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ctl_pkg.sv
// Shared definitions for the writeback-control pipeline: opcodes, writeback
// select encodings, the per-stage record and source-register usage helpers.
package wb_ctl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [1:0]  sel;
    logic        wen;
    logic        is_load;
    logic [4:0]  rd;
    logic [31:0] instr;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '0;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
  endfunction

  // A killed record keeps its payload for trace but can never write back.
  function automatic stage_t kill_stage(input stage_t s);
    stage_t k;
    k       = s;
    k.valid = 1'b0;
    k.wen   = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/wb_ctl_dec.sv
// Combinational writeback-control decoder: instruction to select, write
// enable, load flag, destination and source-register usage.
module wb_ctl_dec
  import wb_ctl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  sel,
  output logic        wen,
  output logic        is_load,
  output logic [4:0]  rd,
  output logic        use_rs1,
  output logic        use_rs2
);

  always_comb begin
    sel     = WB_MEM;
    wen     = 1'b0;
    is_load = 1'b0;
    rd      = instr[11:7];
    use_rs1 = uses_rs1(instr[6:0]);
    use_rs2 = uses_rs2(instr[6:0]);
    case (instr[6:0])
      OP_LUI, OP_AUIPC, OP_IMM, OP_OP: begin
        sel = WB_ALU;
        wen = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        sel = WB_PC4;
        wen = 1'b1;
      end
      OP_LOAD: begin
        wen     = 1'b1;
        is_load = 1'b1;
      end
      default: ;
    endcase
    // x0 is hardwired, so never request a write to it
    if (rd == 5'd0) wen = 1'b0;
  end

endmodule

// File: rtl/wb_ctl_pipe.sv
// Writeback-control pipeline: carries decoded control from acceptance to the
// writeback port with stall, partial flush, load-use interlock and RAW hits.
module wb_ctl_pipe
  import wb_ctl_pkg::*;
#(
  parameter int STAGES       = 3,
  parameter int FLUSH_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              load_use,
  output logic [STAGES-1:0] rs1_hit,
  output logic [STAGES-1:0] rs2_hit,
  output logic              wb_valid,
  output logic [1:0]        wb_sel,
  output logic              reg_wen,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_instr
);

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t dec_rec;

  logic [1:0] dec_sel;
  logic       dec_wen;
  logic       dec_is_load;
  logic [4:0] dec_rd;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       accept;

  wb_ctl_dec u_dec (
    .instr   (instr_in),
    .sel     (dec_sel),
    .wen     (dec_wen),
    .is_load (dec_is_load),
    .rd      (dec_rd),
    .use_rs1 (dec_use_rs1),
    .use_rs2 (dec_use_rs2)
  );

  assign rs1 = instr_in[19:15];
  assign rs2 = instr_in[24:20];

  always_comb begin
    dec_rec         = STAGE_EMPTY;
    dec_rec.valid   = 1'b1;
    dec_rec.sel     = dec_sel;
    dec_rec.wen     = dec_wen;
    dec_rec.is_load = dec_is_load;
    dec_rec.rd      = dec_rd;
    dec_rec.instr   = instr_in;
  end

  // Load data is not ready until the load leaves stage 0, so a dependent
  // instruction must wait one cycle behind a bubble.
  assign load_use = in_valid & stage_q[0].valid & stage_q[0].is_load &
                    (stage_q[0].rd != 5'd0) &
                    ((dec_use_rs1 & (stage_q[0].rd == rs1)) |
                     (dec_use_rs2 & (stage_q[0].rd == rs2)));

  assign in_ready = !stall & !flush & !load_use;
  assign accept   = in_valid & in_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam bit KILL_HERE = (gi < FLUSH_STAGES);
    localparam bit KILL_PREV = (gi <= FLUSH_STAGES);
    stage_t held;
    stage_t src;

    assign held = (flush && KILL_HERE) ? kill_stage(stage_q[gi]) : stage_q[gi];

    if (gi == 0) begin : g_head
      assign src = accept ? dec_rec : STAGE_EMPTY;
    end else begin : g_body
      // A record killed by flush still moves forward, but dead
      assign src = (flush && KILL_PREV) ? kill_stage(stage_q[gi-1]) : stage_q[gi-1];
    end

    assign stage_d[gi] = stall ? held : src;

    assign rs1_hit[gi] = stage_q[gi].valid & stage_q[gi].wen & dec_use_rs1 &
                         (stage_q[gi].rd != 5'd0) & (stage_q[gi].rd == rs1);
    assign rs2_hit[gi] = stage_q[gi].valid & stage_q[gi].wen & dec_use_rs2 &
                         (stage_q[gi].rd != 5'd0) & (stage_q[gi].rd == rs2);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst) stage_q[i] <= STAGE_EMPTY;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign wb_valid = stage_q[STAGES-1].valid;
  assign reg_wen  = stage_q[STAGES-1].valid & stage_q[STAGES-1].wen;
  assign wb_sel   = stage_q[STAGES-1].sel;
  assign wb_rd    = stage_q[STAGES-1].rd;
  assign wb_instr = stage_q[STAGES-1].instr;

endmodule

// File: tb/tb_wb_ctl_pipe.sv
// Scoreboard bench for wb_ctl_pipe: a list-of-live-instructions model predicts
// each cycle's outputs, a negedge monitor pops and compares them.
module tb_wb_ctl_pipe;

  localparam int S = 3;
  localparam int F = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr_in;
  logic          in_valid;
  logic          in_ready;
  logic          stall;
  logic          flush;
  logic          load_use;
  logic [S-1:0]  rs1_hit;
  logic [S-1:0]  rs2_hit;
  logic          wb_valid;
  logic [1:0]    wb_sel;
  logic          reg_wen;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_instr;

  always #5 clk = ~clk;

  wb_ctl_pipe #(.STAGES(S), .FLUSH_STAGES(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr_in (instr_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stall    (stall),
    .flush    (flush),
    .load_use (load_use),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .wb_valid (wb_valid),
    .wb_sel   (wb_sel),
    .reg_wen  (reg_wen),
    .wb_rd    (wb_rd),
    .wb_instr (wb_instr)
  );

  // Model: the live (unkilled) instructions with their distance from acceptance.
  typedef struct {
    logic [31:0] instr;
    int          pos;
  } ent_t;
  ent_t live[$];
  bit   after_rst;

  typedef struct packed {
    logic        in_ready;
    logic        load_use;
    logic [S-1:0] h1;
    logic [S-1:0] h2;
    logic        wbv;
    logic        rwen;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] instr;
    logic        chk_fields;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] m_sel(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17, 7'h13, 7'h33: return 2'b01;
      7'h6F, 7'h67:               return 2'b10;
      default:                    return 2'b00;
    endcase
  endfunction

  function automatic logic m_wen(input logic [31:0] i);
    logic w;
    w = (i[6:0] inside {7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h03});
    return w && (i[11:7] != 5'd0);
  endfunction

  function automatic logic m_u1(input logic [31:0] i);
    return !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic logic m_u2(input logic [31:0] i);
    return (i[6:0] inside {7'h33, 7'h23, 7'h63});
  endfunction

  function automatic exp_t predict(input logic s, input logic f, input logic v,
                                   input logic [31:0] ins);
    exp_t e;
    e = '0;
    foreach (live[k]) begin
      logic [4:0] d;
      d = live[k].instr[11:7];
      if (live[k].pos == 0 && v && live[k].instr[6:0] == 7'h03 && d != 5'd0 &&
          ((m_u1(ins) && d == ins[19:15]) || (m_u2(ins) && d == ins[24:20])))
        e.load_use = 1'b1;
      if (m_wen(live[k].instr)) begin
        if (m_u1(ins) && d == ins[19:15]) e.h1[live[k].pos] = 1'b1;
        if (m_u2(ins) && d == ins[24:20]) e.h2[live[k].pos] = 1'b1;
      end
      if (live[k].pos == S-1) begin
        e.wbv        = 1'b1;
        e.rwen       = m_wen(live[k].instr);
        e.sel        = m_sel(live[k].instr);
        e.rd         = d;
        e.instr      = live[k].instr;
        e.chk_fields = 1'b1;
      end
    end
    e.in_ready = !s && !f && !e.load_use;
    if (after_rst) e.chk_fields = 1'b1;
    return e;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic f,
                            input logic v, input logic [31:0] ins, input logic lu);
    ent_t nq[$];
    if (r) begin
      live.delete();
      after_rst = 1'b1;
      return;
    end
    after_rst = 1'b0;
    foreach (live[k]) begin
      ent_t x;
      x = live[k];
      if (f && x.pos < F) continue;
      if (!s) x.pos++;
      if (x.pos > S-1) continue;
      nq.push_back(x);
    end
    if (!s && !f && v && !lu) nq.push_back('{instr: ins, pos: 0});
    live = nq;
  endtask

  task automatic cycle(input logic r, input logic s, input logic f,
                       input logic v, input logic [31:0] ins);
    exp_t e;
    rst = r; stall = s; flush = f; in_valid = v; instr_in = ins;
    e = predict(s, f, v, ins);
    exp_q.push_back(e);
    @(posedge clk);
    model_step(r, s, f, v, ins, e.load_use);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("in_ready", 32'(in_ready), 32'(e.in_ready));
        chk("load_use", 32'(load_use), 32'(e.load_use));
        chk("rs1_hit",  32'(rs1_hit),  32'(e.h1));
        chk("rs2_hit",  32'(rs2_hit),  32'(e.h2));
        chk("wb_valid", 32'(wb_valid), 32'(e.wbv));
        chk("reg_wen",  32'(reg_wen),  32'(e.rwen));
        if (e.chk_fields) begin
          chk("wb_sel",   32'(wb_sel), 32'(e.sel));
          chk("wb_rd",    32'(wb_rd),  32'(e.rd));
          chk("wb_instr", wb_instr,    e.instr);
        end
        if (e.wbv)
          $display("wb instr=%h rd=%0d sel=%0d wen=%0d", e.instr, e.rd, e.sel, e.rwen);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    logic [31:0] i;
    case ($urandom_range(0, 10))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h13;  3: op = 7'h33;
      4: op = 7'h6F;  5: op = 7'h67;  6: op = 7'h03;  7: op = 7'h03;
      8: op = 7'h23;  9: op = 7'h63;  default: op = 7'h0B;
    endcase
    i        = $urandom;
    i[6:0]   = op;
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin : stim
    int wait_cnt;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; instr_in = '0;
    @(posedge clk);
    #1;
    live.delete();
    after_rst = 1'b1;

    // reset state, in_ready follows stall/flush while in reset
    cycle(1, 1, 0, 0, 32'h0);
    cycle(1, 0, 0, 1, 32'h00500293);
    // addi x5 reaches wb two edges after acceptance
    cycle(0, 0, 0, 1, 32'h00500293);
    cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    // x0 write, store, branch: live at wb without a register write
    cycle(0, 0, 0, 1, 32'h00000013);
    cycle(0, 0, 0, 1, 32'h0062A023);
    cycle(0, 0, 0, 1, 32'h00628463);
    // lw x6 then dependent add: one interlock cycle, then accepted
    cycle(0, 0, 0, 1, 32'h0002A303);
    cycle(0, 0, 0, 1, 32'h006303B3);
    cycle(0, 0, 0, 1, 32'h006303B3);
    cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    // stall with three in flight
    cycle(0, 0, 0, 1, 32'h00100093);
    cycle(0, 0, 0, 1, 32'h00200113);
    cycle(0, 0, 0, 1, 32'h00300193);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 1, 32'h00400213);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 32'h0);
    // flush kills jal in stage 0, addi in stage 1 survives, instr_in dropped
    cycle(0, 0, 0, 1, 32'h00500293);
    cycle(0, 0, 0, 1, 32'h008000EF);
    cycle(0, 0, 1, 1, 32'h00700393);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 32'h0);
    // flush together with stall
    cycle(0, 0, 0, 1, 32'h00500293);
    cycle(0, 0, 0, 1, 32'h008000EF);
    cycle(0, 1, 1, 1, 32'h00700393);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 32'h0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic r, s, f, v;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 4) != 0);
      cycle(r, s, f, v, rand_instr());
    end

    // reset with the pipe full
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 32'h00A00513);
    cycle(1, 0, 0, 1, 32'h00B00593);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h00C00613);
    for (int k = 0; k < S + 1; k++) cycle(0, 0, 0, 0, 32'h0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
